// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes,
// FSM states and the registered control-word layout.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [2:0] aluctl;
    } ctrl_t;

    function automatic logic op_known(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Moore control word for a state; rtype_alu only matters in EXECUTE.
    function automatic ctrl_t ctrl_for(state_e s, logic [2:0] rtype_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluctl  = ALU_ADD;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluctl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluctl  = ALU_ADD;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluctl  = rtype_alu;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluctl  = ALU_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type Funct -> ALUControl decode with a validity flag.
// MUL support is enabled by defining MIPS_CTRL_MUL_EN.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctl_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_ctl_o     = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            F_ADD: alu_ctl_o = ALU_ADD;
            F_SUB: alu_ctl_o = ALU_SUB;
            F_AND: alu_ctl_o = ALU_AND;
            F_OR:  alu_ctl_o = ALU_OR;
            F_SLT: alu_ctl_o = ALU_SLT;
`ifdef MIPS_CTRL_MUL_EN
            F_MUL: alu_ctl_o = ALU_MUL;
`endif
            default: begin
                alu_ctl_o     = ALU_ADD;
                funct_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for the multicycle MIPS core; control word registered from next state.
// MIPS_CTRL_MUL_EN (see mips_alu_decoder) adds the MUL R-type.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [2:0]       ALUControl,
    output logic             IllegalInstr,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam ctrl_t CTRL_FETCH = ctrl_for(S_FETCH, ALU_ADD);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        dec_alu;
    logic              funct_ok;
    logic              retire;
    logic              illegal;

    mips_alu_decoder u_dec (
        .funct_i       (Funct),
        .alu_ctl_o     (dec_alu),
        .funct_valid_o (funct_ok)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Only genuine completions count; illegal aborts return to FETCH from DECODE/EXECUTE.
    assign retire = (state_q == S_MEMWB)  || (state_q == S_MEMWR) ||
                    (state_q == S_ALUWB)  || (state_q == S_BRANCH) ||
                    (state_q == S_ADDIWB) || (state_q == S_JUMP);

    assign illegal = ((state_q == S_DECODE)  && !op_known(Op)) ||
                     ((state_q == S_EXECUTE) && !funct_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            ctrl_q  <= CTRL_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d, dec_alu);
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign IorD         = ctrl_q.iord;
    assign RegDst       = ctrl_q.regdst;
    assign MemtoReg     = ctrl_q.memtoreg;
    assign ALUSrcA      = ctrl_q.alusrca;
    assign ALUSrcB      = ctrl_q.alusrcb;
    assign PCSrc        = ctrl_q.pcsrc;
    assign ALUControl   = ctrl_q.aluctl;
    assign MemWrite     = ctrl_q.memwrite & ~RST;
    assign IRWrite      = ctrl_q.irwrite & ~RST;
    assign RegWrite     = ctrl_q.regwrite & ~RST;
    assign PCEn         = (ctrl_q.pcwrite | (ctrl_q.branch & Zero)) & ~RST;
    assign IllegalInstr = illegal & ~RST;
    assign State        = state_q;
    assign InstrCount   = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: per-cycle expected control vectors queued per instruction, then popped and checked.
module tb_mips_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  Op = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, IllegalInstr;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .IllegalInstr(IllegalInstr),
        .State(State), .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

`ifdef MIPS_CTRL_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    logic [19:0] sb[$];
    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] exp_cnt = 0;
    logic [19:0] obs;

    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, PCSrc, PCEn, ALUControl, IllegalInstr, State};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        ncmp++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic logic [3:0] fdec(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_100;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_110;
            6'b011000: return MUL ? 4'b1_101 : 4'b0_010;
            default:   return 4'b0_010;
        endcase
    endfunction

    function automatic logic [19:0] exp_vec(input int st);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, srca = 0, pcen = 0, ill = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] alu = 3'b000;
        logic [3:0] fd;
        case (st)
            0:  begin irw = 1; pcen = 1; srcb = 2'b01; alu = 3'b010; end
            1:  begin
                    srcb = 2'b11; alu = 3'b010;
                    ill = !(Op == 6'b000000 || Op == 6'b100011 || Op == 6'b101011 ||
                            Op == 6'b000100 || Op == 6'b001000 || Op == 6'b000010);
                end
            2, 9: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin fd = fdec(Funct); srca = 1; alu = fd[2:0]; ill = !fd[3]; end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; alu = 3'b100; pcsrc = 2'b01; pcen = Zero; end
            10: rw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, m2r, rw, srca, srcb, pcsrc, pcen, alu, ill, 4'(st)};
    endfunction

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op = op; Funct = fn; Zero = z;
        #1;
    endtask

    task automatic push(input int st);
        sb.push_back(exp_vec(st));
    endtask

    // Pops one expected vector per cycle, then checks the retire counter back in FETCH.
    task automatic drain(input string tag, input bit retires);
        logic [19:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, 32'(obs), 32'(e));
            @(negedge CLK); #1;
        end
        if (retires) exp_cnt = exp_cnt + 1;
        check({tag, "_cnt"}, InstrCount, exp_cnt);
    endtask

    logic [5:0] rfuncts [5] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        #2;
        check("rst_state", 32'(State), 32'd0);
        check("rst_cnt", InstrCount, 32'd0);
        check("rst_en", 32'({IRWrite, PCEn, RegWrite, MemWrite, IllegalInstr}), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rel_irw", 32'(IRWrite), 32'd1);

        set_instr(6'b100011, 6'd0, 1'b0);
        push(0); push(1); push(2); push(3); push(4);
        drain("lw", 1'b1);

        set_instr(6'b101011, 6'd0, 1'b0);
        push(0); push(1); push(2); push(5);
        drain("sw", 1'b1);

        foreach (rfuncts[i]) begin
            set_instr(6'b000000, rfuncts[i], 1'b0);
            push(0); push(1); push(6); push(7);
            drain($sformatf("rtype_%b", rfuncts[i]), 1'b1);
        end

        set_instr(6'b001000, 6'd0, 1'b0);
        push(0); push(1); push(9); push(10);
        drain("addi", 1'b1);

        set_instr(6'b000100, 6'd0, 1'b1);
        push(0); push(1); push(8);
        drain("beq_taken", 1'b1);

        set_instr(6'b000100, 6'd0, 1'b0);
        push(0); push(1); push(8);
        drain("beq_not", 1'b1);

        set_instr(6'b000010, 6'd0, 1'b0);
        push(0); push(1); push(11);
        drain("jump", 1'b1);

        set_instr(6'b111111, 6'd0, 1'b0);
        push(0); push(1);
        drain("ill_op", 1'b0);

        set_instr(6'b000000, 6'b011000, 1'b0);
        push(0); push(1); push(6);
        if (MUL) push(7);
        drain("funct_mul", MUL);

        set_instr(6'b000000, 6'b000001, 1'b0);
        push(0); push(1); push(6);
        drain("ill_funct", 1'b0);

        // Reset asserted in the middle of a lw, while in MEMRD.
        set_instr(6'b100011, 6'd0, 1'b0);
        push(0); push(1); push(2);
        drain("lw_part", 1'b0);
        check("midrd_state", 32'(State), 32'd3);
        RST = 1'b1;
        #1;
        exp_cnt = 0;
        check("arst_state", 32'(State), 32'd0);
        check("arst_cnt", InstrCount, exp_cnt);
        check("arst_en", 32'({IRWrite, PCEn, RegWrite, MemWrite, IllegalInstr}), 32'd0);
        check("arst_hold", 32'({IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl}), 32'b0_0_01_00_010);
        @(negedge CLK); #1;
        check("arst_held", 32'(State), 32'd0);
        RST = 1'b0;
        #1;
        check("arel_irw", 32'(IRWrite), 32'd1);
        @(posedge CLK); #1;
        check("arel_decode", 32'(State), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
